// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
// LFSR constants are only consumed when MEM_RESP_RANDOM_DELAY_EN is defined.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  LFSR_SEED         = 4'b1001;
  // Feedback taps for x^4 + x^3 + 1 in a left-shifting Fibonacci register
  localparam logic [3:0]  LFSR_TAPS         = 4'b1100;
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;

  function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
    return {cur[2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a core requester (master) and mem_responder (slave).
interface mem_responder_if;

  logic        reqValid;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        respValid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output reqValid, wen, addr, wdata, wstrb,
    input  respValid, rdata, err, busy
  );

  modport slave (
    input  reqValid, wen, addr, wdata, wstrb,
    output respValid, rdata, err, busy
  );

endinterface

// File: rtl/mem_resp_ram.sv
// Word-organised storage: asynchronous read, synchronous byte-strobed write, no reset.
module mem_resp_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane write port
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed or LFSR-driven latency.
// Optional feature macro: MEM_RESP_RANDOM_DELAY_EN (random 1..8 cycle latency).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2'd2);

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               wen_r;
  logic [31:0]        wdata_r;
  logic [3:0]         wstrb_r;
  logic               oor_r;
  logic               resp_valid_r;
  logic [31:0]        rdata_r;
  logic               err_r;
  logic               busy_r;

  logic               req_oor_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [31:0]        ram_rdata_s;
  logic               wr_en_s;
  logic [3:0]         lat_m1_s;

  // Range check and word index of the request currently on the bus
  always_comb begin
    req_oor_s = ({1'b0, bus.addr} < {1'b0, ADDR_BASE}) || ({1'b0, bus.addr} >= ADDR_END);
    req_idx_s = IDX_W'((bus.addr - ADDR_BASE) >> 2'd2);
  end

`ifdef MEM_RESP_RANDOM_DELAY_EN
  logic [3:0] lfsr_r;

  // Free-running latency source, sampled only at accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign lat_m1_s = {1'b0, lfsr_r[2:0]};
`else
  assign lat_m1_s = 4'(LATENCY - 1);
`endif

  // With latency 1 the read is taken straight from the bus address at accept
  assign rd_idx_s = (state_r == ST_IDLE) ? req_idx_s : idx_r;
  // Write lands on the RESP-exit edge, so reads during RESP still see old data
  assign wr_en_s  = (state_r == ST_RESP) && wen_r && !oor_r;

  mem_resp_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_en_s),
    .waddr (idx_r),
    .wdata (wdata_r),
    .wstrb (wstrb_r),
    .raddr (rd_idx_s),
    .rdata (ram_rdata_s)
  );

  // Request FSM with registered response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      idx_r        <= '0;
      wen_r        <= 1'b0;
      wdata_r      <= 32'h0;
      wstrb_r      <= 4'h0;
      oor_r        <= 1'b0;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.reqValid) begin
            idx_r   <= req_idx_s;
            wen_r   <= bus.wen;
            wdata_r <= bus.wdata;
            wstrb_r <= bus.wstrb;
            oor_r   <= req_oor_s;
            busy_r  <= 1'b1;
            cnt_r   <= lat_m1_s;
            if (lat_m1_s == 4'd0) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              err_r        <= req_oor_s;
              rdata_r      <= (bus.wen || req_oor_s) ? 32'h0 : ram_rdata_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_r      <= ST_RESP;
            cnt_r        <= 4'd0;
            resp_valid_r <= 1'b1;
            err_r        <= oor_r;
            rdata_r      <= (wen_r || oor_r) ? 32'h0 : ram_rdata_s;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 4'd0;
          resp_valid_r <= 1'b0;
          rdata_r      <= 32'h0;
          err_r        <= 1'b0;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 4'd0;
          resp_valid_r <= 1'b0;
          rdata_r      <= 32'h0;
          err_r        <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.respValid = resp_valid_r;
  assign bus.rdata     = rdata_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;

endmodule
